bit_serial_subtractor: RTL



---
 rtl/bit_serial_subtractor_pkg.sv | 12 +
 rtl/bit_serial_subtractor_full_subtractor.sv | 13 +
 rtl/bit_serial_subtractor.sv | 117 +++++++++++
 3 files changed

// File: rtl/bit_serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bss_state_t;

  localparam int BSS_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin, producing a difference bit and a borrow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first,
// one bit per clock through a single full subtractor and a borrow flip-flop.
import bit_serial_pkg::*;

module bit_serial_subtractor #(
  parameter int WIDTH = BSS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output bss_state_t       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Handshake: start is sampled only in IDLE; busy is high while bits are
  // processed; done is a one-cycle pulse after the last bit, and diff/bout/ovf
  // stay valid from that pulse until the next accepted start.

  bss_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             sa_q;
  logic             sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= fs_bout;
          diff_q <= {fs_d, diff_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            // fs_d here is the result sign bit; overflow only when operand
            // signs differ and the result sign disagrees with the minuend.
            bout_q  <= fs_bout;
            ovf_q   <= (sa_q != sb_q) & (fs_d != sa_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
